// File: rtl/score_display.sv
// Score renderer: binary score -> BCD via sequential double-dabble, plus a registered glyph pixel
// for the on-screen score field. Optional leading-zero blanking: SCORE_DISPLAY_LEADING_ZERO_BLANK_EN.

module font_rom (
  input  logic [7:0]  addr,
  output logic [15:0] data
);
  // Seven-segment style 16x16 digits; segs = {a,b,c,d,e,f,g}, bit 15 is the leftmost column.
  localparam logic [15:0] H_BAR = 16'h1FF8;
  localparam logic [15:0] LEFT  = 16'h3000;
  localparam logic [15:0] RIGHT = 16'h000C;

  logic [6:0] segs;

  always_comb begin
    segs = 7'b0000000;
    case (addr[7:4])
      4'd0:    segs = 7'b1111110;
      4'd1:    segs = 7'b0110000;
      4'd2:    segs = 7'b1101101;
      4'd3:    segs = 7'b1111001;
      4'd4:    segs = 7'b0110011;
      4'd5:    segs = 7'b1011011;
      4'd6:    segs = 7'b1011111;
      4'd7:    segs = 7'b1110000;
      4'd8:    segs = 7'b1111111;
      4'd9:    segs = 7'b1111011;
      default: segs = 7'b0000000;
    endcase
  end

  always_comb begin
    data = 16'h0000;
    case (addr[3:0])
      4'd1, 4'd2:               data = segs[6] ? H_BAR : 16'h0000;
      4'd3, 4'd4, 4'd5, 4'd6:   data = (segs[1] ? LEFT : 16'h0000) | (segs[5] ? RIGHT : 16'h0000);
      4'd7, 4'd8:               data = segs[0] ? H_BAR : 16'h0000;
      4'd9, 4'd10, 4'd11, 4'd12: data = (segs[2] ? LEFT : 16'h0000) | (segs[4] ? RIGHT : 16'h0000);
      4'd13, 4'd14:             data = segs[3] ? H_BAR : 16'h0000;
      default:                  data = 16'h0000;
    endcase
  end
endmodule

module score_display #(
  parameter int NUM_DIGITS = 4,
  parameter int SCORE_W    = 14,
  parameter int X0         = 400,
  parameter int Y0         = 16
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [SCORE_W-1:0]      score,
  input  logic                    score_load,
  input  logic [9:0]              DrawX,
  input  logic [9:0]              DrawY,
  output logic                    busy,
  output logic                    overflow,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic                    pixel_on
);
  localparam int BCD_W  = 4 * NUM_DIGITS;
  localparam int WORK_W = 4 * (NUM_DIGITS + 1);
  localparam int CNT_W  = $clog2(SCORE_W + 1);
  localparam logic [31:0]      MAX_VAL   = 32'(10 ** NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(SCORE_W - 1);

  // Handshake: score_load is a single-cycle strobe sampled on any clock edge; it always
  // (re)starts a conversion. busy is high from the edge after the load through the commit edge.
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t             state, state_next;
  logic [SCORE_W-1:0] work_bin, bin_next, shift_bin;
  logic [WORK_W-1:0]  work_bcd, bcd_next, shift_bcd, adj_bcd;
  logic [CNT_W-1:0]   iter_cnt, cnt_next;
  logic               ovf_pend, ovf_pend_next;
  logic [BCD_W-1:0]   out_next;
  logic               ovf_next;

  always_comb begin
    adj_bcd = work_bcd;
    for (int i = 0; i < NUM_DIGITS + 1; i++) begin
      if (work_bcd[4*i +: 4] >= 4'd5)
        adj_bcd[4*i +: 4] = work_bcd[4*i +: 4] + 4'd3;
    end
    {shift_bcd, shift_bin} = {adj_bcd, work_bin} << 1;
  end

  always_comb begin
    state_next    = state;
    bin_next      = work_bin;
    bcd_next      = work_bcd;
    cnt_next      = iter_cnt;
    ovf_pend_next = ovf_pend;
    out_next      = bcd_out;
    ovf_next      = overflow;
    if (score_load) begin
      bin_next      = score;
      bcd_next      = '0;
      cnt_next      = '0;
      ovf_pend_next = (32'(score) > MAX_VAL);
      state_next    = SHIFT;
    end else begin
      case (state)
        SHIFT: begin
          bin_next = shift_bin;
          bcd_next = shift_bcd;
          cnt_next = iter_cnt + CNT_W'(1);
          if (iter_cnt == LAST_ITER)
            state_next = COMMIT;
        end
        COMMIT: begin
          out_next   = ovf_pend ? {NUM_DIGITS{4'h9}} : work_bcd[BCD_W-1:0];
          ovf_next   = ovf_pend;
          state_next = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      work_bin <= '0;
      work_bcd <= '0;
      iter_cnt <= '0;
      ovf_pend <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      work_bin <= bin_next;
      work_bcd <= bcd_next;
      iter_cnt <= cnt_next;
      ovf_pend <= ovf_pend_next;
      bcd_out  <= out_next;
      overflow <= ovf_next;
    end
  end

  assign busy = (state != IDLE);

  // Pixel path: field bounds in 11 bits so a field reaching past column 1023 does not wrap.
  localparam logic [10:0] X_LO  = 11'(X0);
  localparam logic [10:0] X_HI  = 11'(X0 + 16 * NUM_DIGITS);
  localparam logic [10:0] Y_LO  = 11'(Y0);
  localparam logic [10:0] Y_HI  = 11'(Y0 + 16);
  localparam logic [9:0]  X0_10 = 10'(X0);
  localparam logic [3:0]  Y0_LO = 4'(Y0);

  logic [10:0] x_ext, y_ext;
  logic        in_field;
  logic [9:0]  rel_x;
  logic [3:0]  rel_y_lo;
  logic [5:0]  idx;
  logic [3:0]  glyph;
  logic [15:0] font_data;
  logic        pixel_next;

  assign x_ext    = {1'b0, DrawX};
  assign y_ext    = {1'b0, DrawY};
  assign in_field = (x_ext >= X_LO) && (x_ext < X_HI) && (y_ext >= Y_LO) && (y_ext < Y_HI);
  assign rel_x    = DrawX - X0_10;
  assign rel_y_lo = DrawY[3:0] - Y0_LO;
  assign idx      = rel_x[9:4];

`ifdef SCORE_DISPLAY_LEADING_ZERO_BLANK_EN
  logic blank;
  logic lead;

  // lead stays set while this digit and every digit to its left are zero.
  always_comb begin
    glyph = 4'd0;
    blank = 1'b0;
    lead  = 1'b1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      lead = lead && (bcd_out[4*(NUM_DIGITS-1-d) +: 4] == 4'd0);
      if (idx == 6'(d)) begin
        glyph = bcd_out[4*(NUM_DIGITS-1-d) +: 4];
        blank = lead && (d < NUM_DIGITS - 1);
      end
    end
  end

  assign pixel_next = (in_field && !blank) ? font_data[~rel_x[3:0]] : 1'b0;
`else
  always_comb begin
    glyph = 4'd0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (idx == 6'(d))
        glyph = bcd_out[4*(NUM_DIGITS-1-d) +: 4];
    end
  end

  assign pixel_next = in_field ? font_data[~rel_x[3:0]] : 1'b0;
`endif

  font_rom u_font_rom (
    .addr ({glyph, rel_y_lo}),
    .data (font_data)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      pixel_on <= 1'b0;
    else
      pixel_on <= pixel_next;
  end
endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display: conversion latency, overflow saturation, restart, reset
// and the glyph pixel path (expected glyph rows written out by hand).

module tb_score_display;
  logic        Clk;
  logic        Reset;
  logic [13:0] score;
  logic        score_load;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        busy;
  logic        overflow;
  logic [15:0] bcd_out;
  logic        pixel_on;

  int n_checks = 0;
  int n_fail   = 0;
  logic [0:0] exp_q[$];

`ifdef SCORE_DISPLAY_LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  // Glyph '2' of the 16x16 font: top bar, upper right, middle bar, lower left, bottom bar.
  logic [15:0] g2 [16] = '{16'h0000, 16'h1FF8, 16'h1FF8, 16'h000C, 16'h000C, 16'h000C,
                           16'h000C, 16'h1FF8, 16'h1FF8, 16'h3000, 16'h3000, 16'h3000,
                           16'h3000, 16'h1FF8, 16'h1FF8, 16'h0000};

  score_display #(
    .NUM_DIGITS (4),
    .SCORE_W    (14),
    .X0         (400),
    .Y0         (16)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .score      (score),
    .score_load (score_load),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .busy       (busy),
    .overflow   (overflow),
    .bcd_out    (bcd_out),
    .pixel_on   (pixel_on)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load(input logic [13:0] v);
    score      = v;
    score_load = 1'b1;
    tick();
    score_load = 1'b0;
  endtask

  // Counts edges until busy drops (bounded); flags whether bcd_out ever showed forbid.
  task automatic wait_done(input logic [15:0] forbid, output int n, output bit seen);
    n    = 0;
    seen = 1'b0;
    while (n < 40) begin
      tick();
      n++;
      if (bcd_out == forbid) seen = 1'b1;
      if (!busy) break;
    end
  endtask

  task automatic pix(input int x, input int y, input logic exp, input string tag);
    DrawX = 10'(x);
    DrawY = 10'(y);
    tick();
    check(tag, 32'(pixel_on), 32'(exp));
  endtask

  initial begin
    int          n;
    bit          seen;
    logic [15:0] row;

    Reset      = 1'b1;
    score      = '0;
    score_load = 1'b0;
    DrawX      = '0;
    DrawY      = '0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bcd", 32'(bcd_out), 32'h0000);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_pix", 32'(pixel_on), 32'd0);
    Reset = 1'b0;
    tick();

    load(14'd1234);
    check("busy_after_load", 32'(busy), 32'd1);
    check("bcd_held_during_conv", 32'(bcd_out), 32'h0000);
    wait_done(16'hFFFF, n, seen);
    check("lat_1234", 32'(n), 32'd15);
    check("bcd_1234", 32'(bcd_out), 32'h1234);
    check("ovf_1234", 32'(overflow), 32'd0);

    for (int y = 16; y < 32; y++) begin
      for (int x = 416; x < 432; x++) begin
        DrawX = 10'(x);
        DrawY = 10'(y);
        row   = g2[y-16];
        exp_q.push_back(row[15-(x-416)]);
        tick();
        check("pix_sweep", 32'(pixel_on), 32'(exp_q.pop_front()));
      end
    end
    pix(399, 20, 1'b0, "pix_x399");
    pix(464, 20, 1'b0, "pix_x464");
    pix(420, 32, 1'b0, "pix_y32");
    pix(420, 15, 1'b0, "pix_y15");
    pix(420, 17, 1'b1, "pix_in_2_top");

    load(14'd12000);
    wait_done(16'hFFFF, n, seen);
    check("bcd_12000", 32'(bcd_out), 32'h9999);
    check("ovf_12000", 32'(overflow), 32'd1);
    load(14'd5);
    wait_done(16'hFFFF, n, seen);
    check("bcd_5", 32'(bcd_out), 32'h0005);
    check("ovf_5", 32'(overflow), 32'd0);
    load(14'd9999);
    wait_done(16'hFFFF, n, seen);
    check("bcd_9999", 32'(bcd_out), 32'h9999);
    check("ovf_9999", 32'(overflow), 32'd0);
    load(14'd10000);
    wait_done(16'hFFFF, n, seen);
    check("bcd_10000", 32'(bcd_out), 32'h9999);
    check("ovf_10000", 32'(overflow), 32'd1);
    load(14'd16383);
    wait_done(16'hFFFF, n, seen);
    check("ovf_16383", 32'(overflow), 32'd1);
    load(14'd807);
    wait_done(16'hFFFF, n, seen);
    check("bcd_807", 32'(bcd_out), 32'h0807);
    check("ovf_807", 32'(overflow), 32'd0);

    load(14'd100);
    repeat (4) tick();
    check("restart_old_held", 32'(bcd_out), 32'h0807);
    load(14'd42);
    wait_done(16'h0100, n, seen);
    check("restart_lat", 32'(n), 32'd15);
    check("restart_no_0100", 32'(seen), 32'd0);
    check("restart_bcd", 32'(bcd_out), 32'h0042);

    pix(453, 17, 1'b1, "pix_pre_reset");
    load(14'd1234);
    tick();
    tick();
    check("busy_mid_shift", 32'(busy), 32'd1);
    Reset = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_bcd", 32'(bcd_out), 32'h0000);
    check("arst_ovf", 32'(overflow), 32'd0);
    check("arst_pix", 32'(pixel_on), 32'd0);
    tick();
    Reset = 1'b0;
    tick();

    load(14'd5);
    wait_done(16'hFFFF, n, seen);
    check("post_rst_lat", 32'(n), 32'd15);
    check("post_rst_bcd", 32'(bcd_out), 32'h0005);
    pix(402, 20, BLANK ? 1'b0 : 1'b1, "lead_pos0");
    pix(434, 20, BLANK ? 1'b0 : 1'b1, "lead_pos2");
    pix(453, 17, 1'b1, "digit5_pos3");

    load(14'd0);
    wait_done(16'hFFFF, n, seen);
    check("bcd_0", 32'(bcd_out), 32'h0000);
    pix(450, 20, 1'b1, "zero_pos3");
    pix(434, 20, BLANK ? 1'b0 : 1'b1, "zero_pos2");
    pix(402, 20, BLANK ? 1'b0 : 1'b1, "zero_pos0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/score_display.md
Name: score_display

Overview:
- Multi-digit score renderer for the VGA overlay.
- Accepts a binary score on a load strobe and converts it to BCD with a sequential double-dabble engine.
- Holds the committed digits in a display register and, for each DrawX/DrawY, outputs a registered font pixel for the on-screen score field.
- Sits between game logic (score counter) and the colour mapper; instantiates one combinational font_rom (8-bit addr, 16-bit row data, 16 rows per glyph, glyphs 0-9 at codes 0-9).

Parameters:
- NUM_DIGITS, 4, number of decimal digits shown, 1..8; digit 0 is leftmost (most significant).
- SCORE_W, 14, width of the binary score input, 1..27.
- X0, 400, left pixel column of the score field, 10-bit.
- Y0, 16, top pixel row of the score field, 10-bit.

Ports:
- Clk  input  1  pixel/system clock.
- Reset  input  1  asynchronous, active-high reset.
- score  input  SCORE_W  binary score, sampled only when score_load=1 and the clock edge occurs.
- score_load  input  1  single-cycle request to convert score.
- DrawX  input  10  current pixel column.
- DrawY  input  10  current pixel row.
- busy  output  1  conversion in progress.
- overflow  output  1  last committed score exceeded 10^NUM_DIGITS-1.
- bcd_out  output  4*NUM_DIGITS  committed BCD digits; the most significant nibble is the leftmost digit.
- pixel_on  output  1  registered glyph pixel for the previous cycle's DrawX/DrawY.

Behaviour:
- Reset (async, Reset=1): state=IDLE; busy=0; overflow=0; bcd_out=0; pixel_on=0; internal shift/BCD work registers=0.
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE + score_load:
  - Capture score.
  - Capture ovf_pend = (score > 10^NUM_DIGITS-1), using a compile-time constant.
  - Clear the work BCD register and the iteration counter.
  - Go to SHIFT; busy=1 from the next cycle.
- SHIFT: one double-dabble iteration per cycle.
  - Add 3 to every work nibble >=5.
  - Then shift {work_bcd, work_bin} left by 1.
  - After exactly SCORE_W iterations, go to COMMIT.
- COMMIT, one cycle:
  - bcd_out = ovf_pend ? all nibbles 9 : work_bcd (low NUM_DIGITS nibbles).
  - overflow = ovf_pend.
  - busy=0; go to IDLE.
- Latency: load sampled at edge t; bcd_out and overflow update at edge t+SCORE_W+1; busy is high for cycles t+1..t+SCORE_W+1.
- The work BCD register is NUM_DIGITS+1 nibbles wide, so no intermediate overflow occurs.
- score_load while busy (SHIFT or COMMIT): restart with the new score, which is captured at that edge. Any in-flight result is discarded, and bcd_out/overflow keep their previous values.
- bcd_out changes only in COMMIT, so the display never shows a partial conversion.
- Pixel path (independent of the FSM, one register stage):
  - relX = DrawX - X0; relY = DrawY - Y0.
  - in_field = (DrawX >= X0) && (DrawX < X0+16*NUM_DIGITS) && (DrawY >= Y0) && (DrawY < Y0+16).
  - idx = relX[9:4]; glyph = bcd_out nibble for digit idx.
  - font_rom addr = glyph*16 + relY[3:0].
  - pixel_on is registered as in_field ? data[15 - relX[3:0]] : 0.
  - Comparisons use unsigned widths of 11 bits, so X0+16*NUM_DIGITS > 1023 does not wrap.
- The pixel path reads bcd_out as it is before the commit edge: a commit becomes visible on the cycle after it occurs.

Optional Feature:
- Macro: SCORE_DISPLAY_LEADING_ZERO_BLANK_EN.
- Defined:
  - Digit positions 0..NUM_DIGITS-2 render blank (pixel_on=0) while they and all digits to their left are 0.
  - The rightmost digit always renders, so a score of 0 shows a single '0'.
  - bcd_out is unaffected; blanking is applied only in the pixel path, with the same 1-cycle latency.
- Not defined: all NUM_DIGITS digits always render, including leading zeros.

Test Plan (defaults NUM_DIGITS=4, SCORE_W=14, X0=400, Y0=16):
- Reset asserted mid-SHIFT -> busy=0, bcd_out=16'h0000, overflow=0 and pixel_on=0 immediately; the next load converts normally.
- Load 1234 at edge t -> busy=1 for cycles t+1..t+15, bcd_out=16'h1234 at edge t+15, overflow=0.
- Load 12000 -> bcd_out=16'h9999, overflow=1; a subsequent load of 5 -> bcd_out=16'h0005, overflow=0.
- Load 100, then load 42 on the 5th busy cycle -> 16'h0100 never appears; bcd_out=16'h0042 exactly 15 edges after the second load.
- With bcd_out=16'h1234, sweep DrawX=416..431 and DrawY=16..31 -> pixel_on one cycle later equals font_rom glyph '2' bits (addr 32..47, MSB at DrawX=416). DrawX=399, DrawX=464 or DrawY=32 -> pixel_on=0.
- With the macro defined: score 5 -> positions 0-2 give pixel_on=0 and position 3 renders '5'; score 0 -> only position 3 renders '0'. Without the macro: score 5 renders "0005".
